iomem_master: RTL and testbench
===============================

# iomem_master

Bus initiator for the PicoSoC `iomem` peripheral port. It accepts single read or write commands on a valid/ready command channel and runs each one as one `iomem` transaction. It waits for the responder's `iomem_ready` pulse, with an optional timeout, and returns the read data and error status on a valid/ready response channel. It lets a non-CPU agent (debug bridge, DMA, test sequencer) drive the same peripherals the CPU reaches through `iomem`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles `iomem_valid` stays high. 0 disables the timeout (waits forever).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid` at a posedge.
- `cmd_addr`  in  32  transaction address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  byte enables; 0 = read.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when high with `rsp_valid` at a posedge.
- `rsp_rdata`  out  32  read data.
- `rsp_error`  out  1  transaction timed out.
- `iomem_valid`  out  1  bus request.
- `iomem_ready`  in  1  responder completion pulse.
- `iomem_wstrb`  out  4  byte enables to the bus.
- `iomem_addr`  out  32  address to the bus.
- `iomem_wdata`  out  32  write data to the bus.
- `iomem_rdata`  in  32  read data from the bus.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, BUS, RESP. Reset forces IDLE.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: register addr, wdata and wstrb onto the `iomem_*` outputs, clear the wait counter, go to BUS.
- BUS
  - `iomem_valid`=1. `iomem_addr`, `iomem_wdata` and `iomem_wstrb` are held stable.
  - The wait counter increments each cycle. Its width is `$clog2(TIMEOUT_CYCLES+1)`, minimum 1, and it saturates without wrapping.
  - `iomem_ready` sampled high: capture `rsp_rdata` = `iomem_rdata` for reads, or 32'h0 for writes; set `rsp_error`=0; go to RESP.
  - Timeout: `TIMEOUT_CYCLES`≠0 and `iomem_valid` has been high for `TIMEOUT_CYCLES` cycles with no `iomem_ready` seen. Then set `rsp_rdata`=32'hFFFF_FFFF and `rsp_error`=1, go to RESP.
  - If `iomem_ready` arrives on the final allowed cycle, ready wins: no error.
- RESP
  - `iomem_valid`=0 and `rsp_valid`=1.
  - `rsp_rdata` and `rsp_error` are held stable until `rsp_ready`, then go to IDLE.
- `cmd_ready`=0 in BUS and RESP. `cmd_*` inputs are ignored outside IDLE.
- `iomem_ready` outside BUS is ignored, including a late ready after a timeout.
- Only one outstanding transaction. No address decode or filtering: every address is issued.

## Timing
- Reset values, applied asynchronously and held while `reset`=1:
  - `iomem_valid`=0, `iomem_addr`=0, `iomem_wdata`=0, `iomem_wstrb`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_error`=0.
  - `busy`=0 and `cmd_ready`=0.
- After `reset` deasserts, `cmd_ready`=1 from the first cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Command accepted at posedge N: `iomem_valid` is high starting the cycle after N.
- `iomem_ready` sampled high at posedge M: `iomem_valid` is low and `rsp_valid` is high starting the cycle after M.
- Against a responder that asserts a registered ready one cycle after seeing valid, `iomem_valid` is high for exactly 2 cycles. This keeps the responder's `!iomem_ready` guard from double-executing the transaction.
- Minimum command-to-command period is 4 cycles: accept, 2× BUS, RESP with `rsp_ready`=1. A new command is accepted on the cycle after the RESP handshake.
- `rsp_valid` never drops without `rsp_ready`.
- Reset mid-BUS or mid-RESP aborts the transaction immediately and produces no response.

## Test plan
- Write, 1-cycle-latency responder: cmd addr=0x0200_0000, wdata=0x000F_F000, wstrb=4'hF → `iomem_valid` high for 2 cycles with stable addr/wdata/wstrb; `rsp_valid` with `rsp_rdata`=0, `rsp_error`=0; responder register now reads 0x000F_F000.
- Read, ready after 5 cycles with `iomem_rdata`=0x1234_5678 → `iomem_valid` high for 5 cycles; `rsp_rdata`=0x1234_5678, `rsp_error`=0.
- Timeout, `TIMEOUT_CYCLES`=8, no ready → `iomem_valid` high for exactly 8 cycles; `rsp_error`=1, `rsp_rdata`=0xFFFF_FFFF. A ready pulse 2 cycles later produces no second response.
- Boundary, `TIMEOUT_CYCLES`=8, ready on the 8th valid cycle with rdata=0xA5A5_A5A5 → `rsp_error`=0, `rsp_rdata`=0xA5A5_A5A5.
- Backpressure: `rsp_ready` low for 4 cycles, with a second `cmd_valid` presented → `rsp_valid`, data and error stable; `cmd_ready`=0 and `busy`=1 throughout. The second command is accepted the cycle after the handshake.
- Reset pulse in the middle of BUS → all outputs 0 immediately; no `rsp_valid`. After release, a fresh read completes normally.

Source files
------------

// File: rtl/iomem_master.sv
// iomem_master: bus initiator for the PicoSoC iomem peripheral port.
//
// Takes one read or write command at a time on a valid/ready command channel and runs it as a
// single iomem transaction. It then waits for the responder's iomem_ready pulse, with an
// optional timeout, and returns read data and error status on a valid/ready response channel.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles iomem_valid stays high; 0 waits forever
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_addr/wdata/wstrb       command fields (wstrb == 0 means read)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata, rsp_error       read data (0 for writes, all-ones on timeout), timeout flag
//   iomem_valid/ready          bus request / responder completion pulse
//   iomem_addr/wdata/wstrb     bus request fields
//   iomem_rdata                bus read data
//   busy                       high whenever a transaction is in flight
module iomem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,

    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,

    output logic        busy
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Counter value seen on the last permitted BUS cycle.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? CNT_MAX
                                                               : CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        error_d = error_q;

        case (state_q)
            IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ready takes priority, so a completion on the final allowed cycle is not an error.
                if (iomem_ready) begin
                    rdata_d = (wstrb_q == 4'h0) ? iomem_rdata : 32'h0;
                    error_d = 1'b0;
                    state_d = RESP;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    rdata_d = 32'hFFFF_FFFF;
                    error_d = 1'b1;
                    state_d = RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so cmd_ready reads 0 while reset is held and needs no path from any input.
        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            rdata_q     <= 32'h0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign iomem_valid = (state_q == BUS);
    assign iomem_addr  = addr_q;
    assign iomem_wdata = wdata_q;
    assign iomem_wstrb = wstrb_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_error   = error_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_iomem_master.sv
// Bench for iomem_master. A transaction-level schedule model predicts, for every cycle, which
// phase (idle / bus / response) the master must be in and what it must present; a responder
// model with a small memory answers bus requests after a programmed number of valid cycles.
module tb_iomem_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    iomem_master #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;        // index of the interval following the latest posedge

    // Schedule model of the transaction in flight.
    bit          in_rst = 1'b1;
    int          rdy_from = 1 << 30;
    bit          have = 1'b0;
    int          cur_acc, cur_vlen, cur_hs;
    logic [31:0] cur_addr, cur_wdata, cur_rdata;
    logic [3:0]  cur_wstrb;
    logic        cur_err;
    int          vobs;      // observed iomem_valid cycles for the current transaction

    // Responder model.
    logic [31:0] mem [logic [31:0]];
    int          resp_lat = 0;     // 0 = never answer
    int          pulse_at = -1;    // interval carrying a stray ready pulse
    int          vcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_iomem_valid"}, 32'(iomem_valid), 32'h0);
        chk({p, "_iomem_addr"},  iomem_addr,         32'h0);
        chk({p, "_iomem_wdata"}, iomem_wdata,        32'h0);
        chk({p, "_iomem_wstrb"}, 32'(iomem_wstrb), 32'h0);
        chk({p, "_rsp_valid"},   32'(rsp_valid),   32'h0);
        chk({p, "_rsp_rdata"},   rsp_rdata,          32'h0);
        chk({p, "_rsp_error"},   32'(rsp_error),   32'h0);
        chk({p, "_busy"},        32'(busy),        32'h0);
        chk({p, "_cmd_ready"},   32'(cmd_ready),   32'h0);
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Responder: ready is raised during the resp_lat-th valid cycle.
    initial begin
        logic [31:0] m;
        logic        hit;
        iomem_ready = 1'b0;
        iomem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            if (iomem_valid) begin
                vcnt++;
                hit = (resp_lat != 0) && (vcnt == resp_lat);
            end else begin
                vcnt = 0;
                hit  = 1'b0;
            end
            if (hit) begin
                iomem_ready = 1'b1;
                if (iomem_wstrb == 4'h0) begin
                    iomem_rdata = rd_mem(iomem_addr);
                end else begin
                    m = rd_mem(iomem_addr);
                    for (int b = 0; b < 4; b++)
                        if (iomem_wstrb[b]) m[8*b +: 8] = iomem_wdata[8*b +: 8];
                    mem[iomem_addr] = m;
                    iomem_rdata = 32'hDEAD_BEEF;
                end
            end else if (cyc == pulse_at) begin
                iomem_ready = 1'b1;
                iomem_rdata = 32'h5555_5555;
            end else begin
                iomem_ready = 1'b0;
                iomem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Per-cycle comparison against the schedule model.
    always @(negedge clk) begin
        if (in_rst) begin
            chk_zero("rst");
        end else if (cyc >= rdy_from) begin
            if (iomem_valid) vobs++;
            if (have && cyc > cur_acc && cyc <= cur_acc + cur_vlen) begin
                chk("bus_iomem_valid", 32'(iomem_valid), 32'h1);
                chk("bus_iomem_addr",  iomem_addr,         cur_addr);
                chk("bus_iomem_wdata", iomem_wdata,        cur_wdata);
                chk("bus_iomem_wstrb", 32'(iomem_wstrb), 32'(cur_wstrb));
                chk("bus_rsp_valid",   32'(rsp_valid),   32'h0);
                chk("bus_cmd_ready",   32'(cmd_ready),   32'h0);
                chk("bus_busy",        32'(busy),        32'h1);
            end else if (have && cyc > cur_acc + cur_vlen && cyc <= cur_hs) begin
                chk("resp_iomem_valid", 32'(iomem_valid), 32'h0);
                chk("resp_rsp_valid",   32'(rsp_valid),   32'h1);
                chk("resp_rsp_rdata",   rsp_rdata,          cur_rdata);
                chk("resp_rsp_error",   32'(rsp_error),   32'(cur_err));
                chk("resp_cmd_ready",   32'(cmd_ready),   32'h0);
                chk("resp_busy",        32'(busy),        32'h1);
            end else begin
                chk("idle_iomem_valid", 32'(iomem_valid), 32'h0);
                chk("idle_rsp_valid",   32'(rsp_valid),   32'h0);
                chk("idle_cmd_ready",   32'(cmd_ready),   32'h1);
                chk("idle_busy",        32'(busy),        32'h0);
            end
        end
    end

    // Runs one transaction presented in the current interval. lat: responder latency in valid
    // cycles (0 = never). bp: response cycles with rsp_ready low. early: present the next command
    // (na/nws) during the response phase. exp_vlen: hand-computed iomem_valid duration.
    task automatic do_txn(input string nm, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int lat, input logic [31:0] rd_exp,
                          input int bp, input int exp_vlen, input bit pulse, input bit early,
                          input logic [31:0] na, input logic [3:0] nws);
        cur_acc   = cyc;
        cur_addr  = a;
        cur_wdata = wd;
        cur_wstrb = ws;
        if (lat == 0 || lat > TO) begin
            cur_vlen  = TO;
            cur_err   = 1'b1;
            cur_rdata = 32'hFFFF_FFFF;
        end else begin
            cur_vlen  = lat;
            cur_err   = 1'b0;
            cur_rdata = (ws == 4'h0) ? rd_exp : 32'h0;
        end
        cur_hs   = cur_acc + cur_vlen + 1 + bp;
        pulse_at = pulse ? cur_acc + cur_vlen + 2 : -1;
        resp_lat = lat;
        have     = 1'b1;
        vobs     = 0;

        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Scramble command inputs after acceptance; bus fields must not follow them.
        cmd_valid = 1'b0;
        cmd_addr  = ~a;
        cmd_wdata = ~wd;
        cmd_wstrb = ~ws;
        while (cyc <= cur_hs) begin
            rsp_ready = (cyc == cur_hs);
            if (early && cyc > cur_acc + cur_vlen) begin
                cmd_addr  = na;
                cmd_wdata = 32'h0;
                cmd_wstrb = nws;
                cmd_valid = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        if (pulse) begin
            repeat (2) begin
                @(posedge clk);
                #1;
            end
        end
        chk({nm, "_valid_cycles"}, 32'(vobs), 32'(exp_vlen));
    endtask

    task automatic reset_mid_bus();
        cur_acc   = cyc;
        cur_addr  = 32'h0400_0000;
        cur_wdata = 32'h0;
        cur_wstrb = 4'h0;
        cur_vlen  = TO;
        cur_hs    = 1 << 30;
        resp_lat  = 0;
        pulse_at  = -1;
        have      = 1'b1;
        cmd_addr  = 32'h0400_0000;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b1;
        in_rst = 1'b1;
        have   = 1'b0;
        #1;
        chk_zero("midbus");
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_rst   = 1'b0;
        rdy_from = cyc + 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        mem[32'h0300_0010] = 32'h1234_5678;
        mem[32'h0300_0020] = 32'hA5A5_A5A5;
        mem[32'h0200_0004] = 32'hCAFE_0001;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_rst   = 1'b0;
        rdy_from = cyc + 1;
        @(posedge clk);
        #1;

        do_txn("wr_full", 32'h0200_0000, 32'h000F_F000, 4'hF, 2, 32'h0, 0, 2, 0, 0, 0, 0);
        do_txn("rd_back", 32'h0200_0000, 32'h0, 4'h0, 2, 32'h000F_F000, 0, 2, 0, 0, 0, 0);
        do_txn("rd_lat5", 32'h0300_0010, 32'h0, 4'h0, 5, 32'h1234_5678, 0, 5, 0, 0, 0, 0);
        do_txn("timeout", 32'h0300_0040, 32'h0, 4'h0, 0, 32'h0, 0, 8, 1, 0, 0, 0);
        do_txn("bound",   32'h0300_0020, 32'h0, 4'h0, 8, 32'hA5A5_A5A5, 0, 8, 0, 0, 0, 0);
        do_txn("wr_half", 32'h0300_0030, 32'h1111_2222, 4'h3, 1, 32'h0, 0, 1, 0, 0, 0, 0);
        do_txn("rd_half", 32'h0300_0030, 32'h0, 4'h0, 1, 32'h0000_2222, 0, 1, 0, 0, 0, 0);
        do_txn("bp_first", 32'h0200_0004, 32'h0, 4'h0, 2, 32'hCAFE_0001, 4, 2, 0, 1,
               32'h0300_0010, 4'h0);
        do_txn("bp_second", 32'h0300_0010, 32'h0, 4'h0, 3, 32'h1234_5678, 0, 3, 0, 0, 0, 0);
        reset_mid_bus();
        do_txn("post_rst", 32'h0300_0010, 32'h0, 4'h0, 2, 32'h1234_5678, 0, 2, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
